// File: rtl/mips_state_dump.sv
// Architectural-state dump engine: streams a register-file window, the low data-memory
// words and (with MIPS_STATE_DUMP_CHECKSUM_EN defined) a trailing checksum beat to a valid/ready sink.
module mips_state_dump #(
  parameter int FIRST_REG = 8,
  parameter int LAST_REG  = 14,
  parameter int MEM_WORDS = 5,
  parameter int DATA_W    = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [4:0]        rf_raddr,
  input  logic [DATA_W-1:0] rf_rdata,
  output logic [31:0]       dm_addr,
  input  logic [DATA_W-1:0] dm_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_tag,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic              dump_done
);

  typedef enum logic [2:0] {
    IDLE,
    REG,
    MEM,
`ifdef MIPS_STATE_DUMP_CHECKSUM_EN
    CSUM,
`endif
    FIN
  } state_t;

  localparam logic [6:0] FIRST_IDX = 7'(FIRST_REG);
  localparam logic [6:0] LAST_IDX  = 7'(LAST_REG);
  localparam logic [6:0] LAST_MEM  = 7'(MEM_WORDS - 1);

  state_t            state, state_nxt;
  logic [6:0]        idx, idx_nxt;
  logic              load;
  logic [DATA_W-1:0] src_data;
  logic [7:0]        src_tag;

`ifdef MIPS_STATE_DUMP_CHECKSUM_EN
  logic [DATA_W-1:0] csum;
`endif

  // Read ports follow idx only while walking their region, so a stall freezes them too.
  assign rf_raddr = (state == REG) ? idx[4:0] : 5'd0;
  assign dm_addr  = (state == MEM) ? {23'd0, idx, 2'b00} : 32'd0;
  assign busy     = (state != IDLE);

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    load      = 1'b0;
    src_data  = rf_rdata;
    src_tag   = {3'b000, idx[4:0]};
    dump_done = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = REG;
          idx_nxt   = FIRST_IDX;
        end
      end
      REG: begin
        load = !out_valid || out_ready;
        if (load) begin
          if (idx == LAST_IDX) begin
            state_nxt = MEM;
            idx_nxt   = 7'd0;
          end else begin
            idx_nxt = idx + 7'd1;
          end
        end
      end
      MEM: begin
        src_data = dm_rdata;
        src_tag  = {1'b1, idx};
        load     = !out_valid || out_ready;
        if (load) begin
          if (idx == LAST_MEM) begin
`ifdef MIPS_STATE_DUMP_CHECKSUM_EN
            state_nxt = CSUM;
`else
            state_nxt = FIN;
`endif
            idx_nxt = 7'd0;
          end else begin
            idx_nxt = idx + 7'd1;
          end
        end
      end
`ifdef MIPS_STATE_DUMP_CHECKSUM_EN
      CSUM: begin
        src_data = csum;
        src_tag  = 8'hFF;
        load     = !out_valid || out_ready;
        if (load) state_nxt = FIN;
      end
`endif
      FIN: begin
        // The final beat is already in the output register; finish on its handshake.
        if (out_valid && out_ready) begin
          state_nxt = IDLE;
          dump_done = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      idx       <= 7'd0;
      out_valid <= 1'b0;
      out_tag   <= 8'd0;
      out_data  <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      if (load) begin
        out_valid <= 1'b1;
        out_tag   <= src_tag;
        out_data  <= src_data;
      end else if (state == FIN && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef MIPS_STATE_DUMP_CHECKSUM_EN
  // Running sum of every register and memory word emitted, wrapping at the word width.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      csum <= '0;
    end else if (state == IDLE && start) begin
      csum <= '0;
    end else if (load && (state == REG || state == MEM)) begin
      csum <= csum + src_data;
    end
  end
`endif

endmodule

// File: tb/tb_mips_state_dump.sv
// Directed bench for mips_state_dump: basic dump, backpressure, start-while-busy,
// reset mid-dump and a single-register/single-word parameter corner.
module tb_mips_state_dump;

  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [4:0]        rf_raddr;
  logic [DATA_W-1:0] rf_rdata;
  logic [31:0]       dm_addr;
  logic [DATA_W-1:0] dm_rdata;
  logic              out_valid;
  logic              out_ready;
  logic [7:0]        out_tag;
  logic [DATA_W-1:0] out_data;
  logic              busy;
  logic              dump_done;

  logic              c_start;
  logic [4:0]        c_rf_raddr;
  logic [DATA_W-1:0] c_rf_rdata;
  logic [31:0]       c_dm_addr;
  logic [DATA_W-1:0] c_dm_rdata;
  logic              c_out_valid;
  logic              c_out_ready;
  logic [7:0]        c_out_tag;
  logic [DATA_W-1:0] c_out_data;
  logic              c_busy;
  logic              c_dump_done;

  logic [DATA_W-1:0] rf_mem [32];
  logic [DATA_W-1:0] dm_mem [128];

  assign rf_rdata   = rf_mem[rf_raddr];
  assign dm_rdata   = dm_mem[dm_addr[8:2]];
  assign c_rf_rdata = rf_mem[c_rf_raddr];
  assign c_dm_rdata = dm_mem[c_dm_addr[8:2]];

  always #5 clk = ~clk;

  mips_state_dump #(.FIRST_REG(8), .LAST_REG(14), .MEM_WORDS(5), .DATA_W(DATA_W)) u_dut (
    .clk(clk), .reset(rst_n), .start(start),
    .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
    .dm_addr(dm_addr), .dm_rdata(dm_rdata),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_tag(out_tag), .out_data(out_data),
    .busy(busy), .dump_done(dump_done)
  );

  mips_state_dump #(.FIRST_REG(31), .LAST_REG(31), .MEM_WORDS(1), .DATA_W(DATA_W)) u_dut_c (
    .clk(clk), .reset(rst_n), .start(c_start),
    .rf_raddr(c_rf_raddr), .rf_rdata(c_rf_rdata),
    .dm_addr(c_dm_addr), .dm_rdata(c_dm_rdata),
    .out_valid(c_out_valid), .out_ready(c_out_ready),
    .out_tag(c_out_tag), .out_data(c_out_data),
    .busy(c_busy), .dump_done(c_dump_done)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected beat sequence of the main instance.
  logic [7:0]        exp_tag  [16];
  logic [DATA_W-1:0] exp_data [16];
  int                n_exp;

  // Accepted-beat log filled by the monitor.
  logic [7:0]        q_tag  [$];
  logic [DATA_W-1:0] q_data [$];
  int                done_cnt;
  int                done_at;
  logic              stall_prev;
  logic [7:0]        p_tag;
  logic [DATA_W-1:0] p_data;

  // Inputs change 1ns after posedge, so the negedge view equals the next edge's handshake.
  always @(negedge clk) begin
    if (!rst_n) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev)
        check_eq("stall_hold", 64'({out_valid, out_tag, out_data}), 64'({1'b1, p_tag, p_data}));
      if (out_valid && out_ready) begin
        q_tag.push_back(out_tag);
        q_data.push_back(out_data);
      end
      if (dump_done) begin
        done_cnt++;
        done_at = q_tag.size();
      end
      stall_prev = out_valid && !out_ready;
      p_tag      = out_tag;
      p_data     = out_data;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    q_tag.delete();
    q_data.delete();
    done_cnt = 0;
    done_at  = -1;
  endtask

  task automatic wait_idle(input string name, input int max_cyc);
    int c = 0;
    while (busy && c < max_cyc) begin
      step();
      c++;
    end
    check_eq({name, "_idle_bound"}, 64'(busy), 64'(0));
  endtask

  task automatic check_seq(input string name);
    check_eq({name, "_beats"}, 64'(q_tag.size()), 64'(n_exp));
    for (int i = 0; i < n_exp && i < q_tag.size(); i++) begin
      check_eq($sformatf("%s_tag%0d", name, i), 64'(q_tag[i]), 64'(exp_tag[i]));
      check_eq($sformatf("%s_data%0d", name, i), 64'(q_data[i]), 64'(exp_data[i]));
    end
    check_eq({name, "_done_cnt"}, 64'(done_cnt), 64'(1));
    check_eq({name, "_done_at"}, 64'(done_at), 64'(n_exp));
  endtask

  task automatic run_basic(input string name);
    clear_log();
    out_ready = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    check_eq({name, "_busy_e0"}, 64'(busy), 64'(1));
    check_eq({name, "_valid_e0"}, 64'(out_valid), 64'(0));
    check_eq({name, "_raddr_e0"}, 64'(rf_raddr), 64'(8));
    step();
    check_eq({name, "_valid_e1"}, 64'(out_valid), 64'(1));
    check_eq({name, "_tag_e1"}, 64'(out_tag), 64'(8'h08));
    wait_idle(name, 100);
    step();
    check_seq(name);
  endtask

  logic [7:0]        c_tag  [$];
  logic [DATA_W-1:0] c_data [$];
  int                c_done;
  logic [DATA_W-1:0] csum_model;

  initial begin
    for (int i = 0; i < 32; i++) rf_mem[i] = 32'h1000 + 32'(i);
    for (int i = 0; i < 128; i++) dm_mem[i] = 32'h2000 + 32'(i);
    for (int i = 8; i <= 14; i++) rf_mem[i] = 32'(5 * (i - 7));
    for (int i = 0; i < 5; i++) dm_mem[i] = 32'(17 * (i + 1));
    rf_mem[31] = 32'hCAFE_F00D;

    csum_model = '0;
    for (int i = 0; i < 7; i++) begin
      exp_tag[i]  = 8'(8 + i);
      exp_data[i] = rf_mem[8 + i];
      csum_model  = csum_model + rf_mem[8 + i];
    end
    for (int i = 0; i < 5; i++) begin
      exp_tag[7 + i]  = 8'h80 + 8'(i);
      exp_data[7 + i] = dm_mem[i];
      csum_model      = csum_model + dm_mem[i];
    end
    n_exp = 12;
`ifdef MIPS_STATE_DUMP_CHECKSUM_EN
    exp_tag[12]  = 8'hFF;
    exp_data[12] = csum_model;
    n_exp = 13;
`endif

    rst_n = 1'b0;
    start = 1'b0;
    c_start = 1'b0;
    out_ready = 1'b1;
    c_out_ready = 1'b1;
    clear_log();
    #22;
    check_eq("rst_valid", 64'(out_valid), 64'(0));
    check_eq("rst_busy", 64'(busy), 64'(0));
    check_eq("rst_done", 64'(dump_done), 64'(0));
    check_eq("rst_tag", 64'(out_tag), 64'(0));
    check_eq("rst_data", 64'(out_data), 64'(0));
    check_eq("rst_raddr", 64'(rf_raddr), 64'(0));
    check_eq("rst_dmaddr", 64'(dm_addr), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    step();

    run_basic("basic");

    // Backpressure: 3-cycle stall on tag 0A, then out_ready toggles every cycle.
    clear_log();
    out_ready = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 0; c < 20 && !(out_valid && out_tag == 8'h0A); c++) step();
    check_eq("bp_reach_0A", 64'(out_tag), 64'(8'h0A));
    out_ready = 1'b0;
    repeat (3) step();
    check_eq("bp_hold_data", 64'(out_data), 64'(32'h0F));
    out_ready = 1'b1;
    for (int c = 0; c < 200 && busy; c++) begin
      step();
      out_ready = ~out_ready;
    end
    check_eq("bp_idle_bound", 64'(busy), 64'(0));
    out_ready = 1'b1;
    step();
    check_seq("bp");

    // Start pulses while busy (at beat 5) and in the dump_done cycle are ignored.
    clear_log();
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 0; c < 100 && busy; c++) begin
      step();
      start = (out_valid && out_tag == 8'h0C) || dump_done;
    end
    start = 1'b0;
    check_eq("sb_idle_bound", 64'(busy), 64'(0));
    repeat (3) step();
    check_eq("sb_stay_idle", 64'(busy), 64'(0));
    check_seq("sb");

    // Reset mid-dump at tag 80, then a fresh dump from tag 08.
    clear_log();
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 0; c < 30 && !(out_valid && out_tag == 8'h80); c++) step();
    check_eq("rm_reach_80", 64'(out_tag), 64'(8'h80));
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("rm_valid", 64'(out_valid), 64'(0));
    check_eq("rm_busy", 64'(busy), 64'(0));
    check_eq("rm_data", 64'(out_data), 64'(0));
    check_eq("rm_tag", 64'(out_tag), 64'(0));
    step();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) step();
    check_eq("rm_no_restart", 64'(busy), 64'(0));
    run_basic("rm_again");

    // Single-register / single-word corner instance.
    c_tag.delete();
    c_data.delete();
    c_done = 0;
    c_start = 1'b1;
    step();
    c_start = 1'b0;
    check_eq("c_raddr", 64'(c_rf_raddr), 64'(31));
    for (int c = 0; c < 20 && c_busy; c++) begin
      step();
      if (c_out_valid) begin
        c_tag.push_back(c_out_tag);
        c_data.push_back(c_out_data);
        if (c_out_tag == 8'h1F) check_eq("c_dmaddr", 64'(c_dm_addr), 64'(0));
      end
      if (c_dump_done) c_done++;
    end
    check_eq("c_idle_bound", 64'(c_busy), 64'(0));
`ifdef MIPS_STATE_DUMP_CHECKSUM_EN
    check_eq("c_beats", 64'(c_tag.size()), 64'(3));
`else
    check_eq("c_beats", 64'(c_tag.size()), 64'(2));
`endif
    if (c_tag.size() >= 2) begin
      check_eq("c_tag0", 64'(c_tag[0]), 64'(8'h1F));
      check_eq("c_data0", 64'(c_data[0]), 64'(32'hCAFE_F00D));
      check_eq("c_tag1", 64'(c_tag[1]), 64'(8'h80));
      check_eq("c_data1", 64'(c_data[1]), 64'(32'h11));
    end
    check_eq("c_done_cnt", 64'(c_done), 64'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
